// File: rtl/led_link_indicator.sv
// led_link_indicator
// ------------------
// Per-port LED pattern generator. Consumes the link-up level, the flap
// indication from the upstream flap detector and a per-frame activity strobe,
// and drives a single LED with one of four patterns:
//   - off                      : link down
//   - solid on                 : link up, idle
//   - short off-blinks         : traffic
//   - fast continuous blinking : link flapping (persists FlapHold cycles)
// The LED output comes straight from a flop, so it can be routed to a pin.
//
// Ports:
//   clk      in  1  block clock
//   reset_n  in  1  asynchronous active-low reset
//   link_up  in  1  link status level, 1 = up
//   flap     in  1  flap indication level from the flap detector
//   activity in  1  one-cycle strobe per frame (may be held high)
//   led      out 1  LED drive, 1 = lit, registered

module led_link_indicator #(
    parameter int unsigned BlinkHalfPeriod = 6250000,
    parameter int unsigned ActivityHold    = 2500000,
    parameter int unsigned FlapHold        = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic link_up,
    input  logic flap,
    input  logic activity,
    output logic led
);

    localparam int unsigned MaxAB    = (BlinkHalfPeriod > ActivityHold) ? BlinkHalfPeriod : ActivityHold;
    localparam int unsigned MaxParam = (MaxAB > FlapHold) ? MaxAB : FlapHold;
    localparam int unsigned CntW     = $clog2(MaxParam + 1);

    // A parameter of 1 loads 0, giving a one-cycle phase.
    localparam logic [CntW-1:0] BlinkReload = CntW'(BlinkHalfPeriod - 1);
    localparam logic [CntW-1:0] ActReload   = CntW'(ActivityHold - 1);
    localparam logic [CntW-1:0] HoldReload  = CntW'(FlapHold - 1);
    localparam logic [CntW-1:0] CntOne      = CntW'(1);

    typedef enum logic [2:0] {
        S_DOWN,
        S_UP,
        S_ACT_OFF,
        S_ACT_ON,
        S_FLAP
    } state_e;

    state_e          state_q, state_d;
    logic            led_q, led_d;
    logic [CntW-1:0] blink_cnt_q, blink_cnt_d;
    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic [CntW-1:0] act_cnt_q, act_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_DOWN;
            led_q       <= 1'b0;
            blink_cnt_q <= '0;
            hold_cnt_q  <= '0;
            act_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            blink_cnt_q <= blink_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            act_cnt_q   <= act_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        led_d       = led_q;
        blink_cnt_d = blink_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        act_cnt_d   = act_cnt_q;

        // Flap outranks everything; once in FLAP the pattern runs on its own.
        if (flap && (state_q != S_FLAP)) begin
            state_d     = S_FLAP;
            led_d       = 1'b1;
            blink_cnt_d = BlinkReload;
            hold_cnt_d  = HoldReload;
        end else begin
            case (state_q)
                S_FLAP: begin
                    if (blink_cnt_q == '0) begin
                        led_d       = ~led_q;
                        blink_cnt_d = BlinkReload;
                    end else begin
                        blink_cnt_d = blink_cnt_q - CntOne;
                    end

                    // Hold-off timer only runs once flap has gone quiet.
                    if (flap) begin
                        hold_cnt_d = HoldReload;
                    end else if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - CntOne;
                    end

                    if (!flap && (hold_cnt_q == '0)) begin
                        state_d = link_up ? S_UP : S_DOWN;
                        led_d   = link_up;
                    end
                end

                S_DOWN: begin
                    // A coincident activity strobe is intentionally dropped.
                    if (link_up) begin
                        state_d = S_UP;
                        led_d   = 1'b1;
                    end
                end

                S_UP: begin
                    if (!link_up) begin
                        state_d = S_DOWN;
                        led_d   = 1'b0;
                    end else if (activity) begin
                        state_d   = S_ACT_OFF;
                        led_d     = 1'b0;
                        act_cnt_d = ActReload;
                    end
                end

                S_ACT_OFF: begin
                    if (!link_up) begin
                        state_d = S_DOWN;
                        led_d   = 1'b0;
                    end else if (act_cnt_q == '0) begin
                        state_d   = S_ACT_ON;
                        led_d     = 1'b1;
                        act_cnt_d = ActReload;
                    end else begin
                        act_cnt_d = act_cnt_q - CntOne;
                    end
                end

                S_ACT_ON: begin
                    if (!link_up) begin
                        state_d = S_DOWN;
                        led_d   = 1'b0;
                    end else if (act_cnt_q == '0) begin
                        // The on-phase has elapsed, so the blink is re-armed on
                        // this edge: held activity restarts the off-phase
                        // directly, giving an exact ActivityHold off/on square
                        // wave rather than one stretched by an idle UP cycle.
                        if (activity) begin
                            state_d   = S_ACT_OFF;
                            led_d     = 1'b0;
                            act_cnt_d = ActReload;
                        end else begin
                            state_d = S_UP;
                            led_d   = 1'b1;
                        end
                    end else begin
                        act_cnt_d = act_cnt_q - CntOne;
                    end
                end

                default: begin
                    state_d = S_DOWN;
                    led_d   = 1'b0;
                end
            endcase
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_link_indicator.sv
// Testbench for led_link_indicator (BlinkHalfPeriod=4, ActivityHold=3,
// FlapHold=8). Directed scenarios use expected LED sequences written out by
// hand; the random scenario uses a mode/elapsed-time reference model.
module tb_led_link_indicator;

    localparam int BHP = 4;
    localparam int AH  = 3;
    localparam int FH  = 8;

    logic clk;
    logic reset_n;
    logic link_up;
    logic flap;
    logic activity;
    logic led;

    int checks;
    int errors;

    // Reference model state: mode, cycles since entering the mode, and number
    // of consecutive flap-free samples while flapping.
    localparam int MD_DOWN = 0;
    localparam int MD_UP   = 1;
    localparam int MD_ACT  = 2;
    localparam int MD_FLAP = 3;
    int m_mode;
    int m_t;
    int m_quiet;
    bit m_led;

    led_link_indicator #(
        .BlinkHalfPeriod(BHP),
        .ActivityHold   (AH),
        .FlapHold       (FH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .link_up (link_up),
        .flap    (flap),
        .activity(activity),
        .led     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_mode  = MD_DOWN;
        m_t     = 0;
        m_quiet = 0;
        m_led   = 1'b0;
    endtask

    task automatic model_step(input bit l, input bit f, input bit a);
        if (f && m_mode != MD_FLAP) begin
            m_mode  = MD_FLAP;
            m_t     = 0;
            m_quiet = 0;
        end else if (m_mode == MD_FLAP) begin
            m_quiet = f ? 0 : m_quiet + 1;
            if (m_quiet >= FH) begin
                m_mode = l ? MD_UP : MD_DOWN;
                m_t    = 0;
            end else begin
                m_t++;
            end
        end else if (!l) begin
            m_mode = MD_DOWN;
        end else begin
            case (m_mode)
                MD_DOWN: m_mode = MD_UP;
                MD_UP: if (a) begin
                    m_mode = MD_ACT;
                    m_t    = 0;
                end
                MD_ACT: begin
                    m_t++;
                    if (m_t == 2 * AH) begin
                        if (a) m_t = 0;
                        else   m_mode = MD_UP;
                    end
                end
                default: m_mode = MD_DOWN;
            endcase
        end
        case (m_mode)
            MD_UP:   m_led = 1'b1;
            MD_ACT:  m_led = (m_t >= AH);
            MD_FLAP: m_led = ((m_t / BHP) % 2) == 0;
            default: m_led = 1'b0;
        endcase
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        link_up  = 1'b1;
        flap     = 1'b0;
        activity = 1'b0;
        #1;
        checks++;
        if (led !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: led=%b expected 0", led);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (led !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: led=%b expected 0", i, led);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (led !== 1'b1) begin
                errors++;
                $display("FAIL reset_release cycle %0d: led=%b expected 1", i, led);
            end
        end
    endtask

    task automatic test_activity_single();
        bit exp [0:7];
        exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            activity = (i == 0) || (i == 4);
            cyc();
            checks++;
            if (led !== exp[i]) begin
                errors++;
                $display("FAIL act_single edge N+%0d: led=%b expected %b", i, led, exp[i]);
            end
        end
        activity = 1'b0;
    endtask

    task automatic test_activity_continuous();
        activity = 1'b1;
        for (int i = 0; i < 18; i++) begin
            cyc();
            checks++;
            if (led !== ((i % 6) >= 3)) begin
                errors++;
                $display("FAIL act_cont edge %0d: led=%b expected %b", i, led, ((i % 6) >= 3));
            end
        end
        activity = 1'b0;
        cyc();
        checks++;
        if (led !== 1'b1) begin
            errors++;
            $display("FAIL act_cont_idle: led=%b expected 1", led);
        end
    endtask

    task automatic test_flap_pulse();
        bit exp [0:12];
        exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 13; i++) begin
            flap = (i == 0);
            cyc();
            checks++;
            if (led !== exp[i]) begin
                errors++;
                $display("FAIL flap_pulse edge N+%0d: led=%b expected %b", i, led, exp[i]);
            end
        end
        flap = 1'b0;
    endtask

    task automatic test_link_drop();
        activity = 1'b1;
        cyc();
        activity = 1'b0;
        cyc();
        checks++;
        if (led !== 1'b0) begin
            errors++;
            $display("FAIL link_drop_actoff: led=%b expected 0", led);
        end
        link_up = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (led !== 1'b0) begin
                errors++;
                $display("FAIL link_drop_down cycle %0d: led=%b expected 0", i, led);
            end
        end
        link_up  = 1'b1;
        activity = 1'b1;
        cyc();
        activity = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (led !== 1'b1) begin
                errors++;
                $display("FAIL link_raise_no_blink cycle %0d: led=%b expected 1", i, led);
            end
            cyc();
        end
    endtask

    task automatic test_flap_down();
        bit exp [0:11];
        exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b0, 1'b0};
        link_up = 1'b0;
        cyc();
        checks++;
        if (led !== 1'b0) begin
            errors++;
            $display("FAIL flap_down_pre: led=%b expected 0", led);
        end
        for (int i = 0; i < 12; i++) begin
            flap = (i < 3);
            cyc();
            checks++;
            if (led !== exp[i]) begin
                errors++;
                $display("FAIL flap_down edge E+%0d: led=%b expected %b", i, led, exp[i]);
            end
        end
        flap = 1'b0;
    endtask

    task automatic test_async_reset();
        link_up = 1'b1;
        cyc();
        flap = 1'b1;
        cyc();
        flap = 1'b0;
        cyc();
        checks++;
        if (led !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_flap: led=%b expected 1", led);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (led !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: led=%b expected 0", led);
        end
        cyc();
        reset_n = 1'b1;
        cyc();
        checks++;
        if (led !== 1'b1) begin
            errors++;
            $display("FAIL async_release_up: led=%b expected 1", led);
        end
    endtask

    task automatic test_random();
        int flap_left;
        bit burst_act;
        reset_n  = 1'b0;
        link_up  = 1'b1;
        flap     = 1'b0;
        activity = 1'b0;
        model_reset();
        cyc();
        reset_n   = 1'b1;
        flap_left = 0;
        burst_act = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) link_up = ~link_up;
            if (!link_up && $urandom_range(0, 19) == 0) link_up = 1'b1;
            if (flap_left > 0) begin
                flap_left--;
            end else if ($urandom_range(0, 249) == 0) begin
                flap_left = $urandom_range(1, 6);
            end
            flap = (flap_left > 0);
            if ($urandom_range(0, 59) == 0) burst_act = ~burst_act;
            activity = burst_act ? 1'b1 : ($urandom_range(0, 7) == 0);
            cyc();
            model_step(link_up, flap, activity);
            checks++;
            if (led !== m_led) begin
                errors++;
                $display("FAIL random cycle %0d: led=%b expected %b (link=%b flap=%b act=%b)",
                         i, led, m_led, link_up, flap, activity);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_activity_single();
        test_activity_continuous();
        test_flap_pulse();
        test_link_drop();
        test_flap_down();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
